instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory that the single-cycle datapath only reads.
//  Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
//  Writes each word into instruction memory at consecutive byte addresses (step 4).
//  Holds the CPU (PC/fetch) off while loading and signals completion.
// PARAMETERS
//  MEM_WORDS  256  capacity of instruction memory in 32-bit words
//  BASE_ADDR  0    byte address of the first word written (multiple of 4)
//  CNT_W      16   width of word_count
// PORTS
//  clk         in   1      system clock; all state changes on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request a load session (sampled in IDLE only)
//  word_count  in   CNT_W  number of words to load; sampled with start
//  rx_valid    in   1      byte available from sender
//  rx_data     in   8      byte value
//  rx_ready    out  1      loader accepts byte this cycle
//  mem_we      out  1      instruction-memory write strobe, one cycle per word
//  mem_addr    out  32     byte address of write (BASE_ADDR + 4*index)
//  mem_wdata   out  32     assembled instruction word
//  cpu_hold    out  1      1 = CPU must not fetch/advance PC
//  busy        out  1      session in progress
//  done        out  1      one-cycle pulse at successful end of session
//  err         out  1      one-cycle pulse, session rejected
// BEHAVIOUR
//  - Reset: state IDLE; rx_ready, mem_we, cpu_hold, busy, done, err = 0; mem_addr, mem_wdata = 0;
//    byte/word counters cleared. Reset mid-session discards the partial word; no write is issued.
//  - FSM: IDLE -> RECV -> WRITE -> (RECV | DONE) -> IDLE; IDLE -> ERR -> IDLE.
//  - IDLE: start=1 with word_count in 1..MEM_WORDS -> RECV, latch count, index=0.
//    start=1 with word_count=0 -> DONE (done pulse next cycle, no write).
//    start=1 with word_count>MEM_WORDS -> ERR (err pulse, no write).
//  - RECV: rx_ready=1. A byte is taken only when rx_valid & rx_ready. First byte -> [31:24],
//    then [23:16], [15:8], [7:0] (big-endian, MIPS order). rx_valid may drop between bytes with no effect.
//    After the 4th accepted byte -> WRITE.
//  - WRITE: rx_ready=0; mem_we=1 for exactly one cycle; mem_addr=BASE_ADDR+4*index;
//    mem_wdata=assembled word. Latency: 1 cycle from 4th-byte handshake to mem_we.
//    index+1 == count -> DONE, else index++ and -> RECV.
//  - DONE: done=1 for one cycle -> IDLE. ERR: err=1 for one cycle -> IDLE.
//  - busy=1 and cpu_hold=1 in RECV, WRITE and DONE; both 0 in IDLE and ERR.
//  - start is ignored outside IDLE; rx_valid is ignored outside RECV (sender holds the byte).
//  - mem_addr and mem_wdata are 0 whenever mem_we=0. Index never wraps: count <= MEM_WORDS is enforced.
// STRUCTURE
//  - Shared package loader_pkg: state encodings (IDLE, RECV, WRITE, DONE, ERR) and BYTES_PER_WORD=4.
//  - Sub-module byte_assembler: 2-bit byte counter plus a 32-bit shift register; outputs word
//    and word_ready. Cleared by rst or session start.
//  - Top level: FSM, word index counter, address generation, hold/done/err logic.
// TESTING
//  1. start, word_count=1, bytes 20 08 00 05 -> one mem_we, addr 0x0, wdata 0x20080005; done pulse; cpu_hold drops.
//  2. word_count=3, rx_valid with random gaps -> writes to 0x0, 0x4, 0x8 in order, each mem_we one cycle wide.
//  3. word_count=0 -> done one cycle after start; mem_we never asserted; busy and cpu_hold high only in the DONE cycle.
//  4. word_count=MEM_WORDS+1 -> err pulse; no mem_we; rx_ready stays 0.
//  5. rst after 2 bytes -> all outputs 0 next cycle; new session writes a clean word at 0x0.
//  6. start pulsed while busy, and rx_valid while IDLE -> no effect; byte count and addresses unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: session states and word geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word; flags the handshake that completes a word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (take_i) begin
            cnt_d  = cnt_q + 2'd1;
            // Shifting left puts the first byte of the word in [31:24].
            word_d = {word_q[23:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = take_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-streamed program into instruction memory, one word per write, holding the CPU meanwhile.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(MEM_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word;
    logic             word_ready;
    logic             start_acc;
    logic             last_word;

    assign start_acc = (state_q == IDLE) && start;
    assign last_word = (idx_q + CNT_W'(1)) == cnt_q;

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_acc),
        .take_i       (rx_valid && rx_ready),
        .byte_i       (rx_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else if ({1'b0, word_count} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV:    if (word_ready) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : RECV;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word index and session length; the length check above keeps the index below MEM_WORDS.
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (start_acc) begin
            idx_d = '0;
            cnt_d = word_count;
        end else if (state_q == WRITE && !last_word) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_hold  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = 32'(BASE_ADDR) + (32'(idx_q) << 2);
                mem_wdata = word;
                busy      = 1'b1;
                cpu_hold  = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a transaction-level write model and per-cycle bus checks.
module tb_instr_mem_loader;

    localparam int MEM_WORDS = 256;
    localparam int BASE_ADDR = 0;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready, mem_we, cpu_hold, busy, done, err;
    logic [31:0]      mem_addr, mem_wdata;

    instr_mem_loader #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] prog[$];
    int         gaps[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;
    logic       prev_we = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected writes follow directly from the program bytes: word w = bytes 4w..4w+3, MSB first.
    task automatic expect_program();
        for (int w = 0; w < prog.size() / 4; w++) begin
            wr_t e;
            e.addr = 32'(BASE_ADDR + 4 * w);
            e.data = {prog[4*w], prog[4*w+1], prog[4*w+2], prog[4*w+3]};
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                wr_t e;
                check("we_one_cycle", 64'(prev_we), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata), 64'(e.data));
                end
            end else begin
                check("bus_zero_no_we", {mem_addr, mem_wdata}, 64'd0);
            end
            check("hold_eq_busy", 64'(cpu_hold), 64'(busy));
            prev_we = mem_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input int wc);
        start      = 1'b1;
        word_count = CNT_W'(wc);
        tick();
        start      = 1'b0;
        word_count = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            tick();
        end
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_program(input int from);
        for (int i = from; i < prog.size(); i++) begin
            send_byte(prog[i], (gaps.size() != 0) ? gaps[i % gaps.size()] : 0);
        end
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_has_hold", 64'(cpu_hold), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("hold_released", 64'(cpu_hold), 64'd0);
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_flags", 64'({rx_ready, mem_we, cpu_hold, busy, done, err}), 64'd0);
        tick();

        // 1: single word
        prog = '{8'h20, 8'h08, 8'h00, 8'h05};
        gaps = {};
        expect_program();
        check("model_word", 64'(exp_q[0].data), 64'h20080005);
        start_session(1);
        send_program(0);
        @(negedge clk);
        check("t1_we", 64'(mem_we), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'h0);
        check("t1_wdata", 64'(mem_wdata), 64'h20080005);
        @(negedge clk);
        check("t1_done", 64'(done), 64'd1);
        @(negedge clk);
        check("t1_hold_drop", 64'({cpu_hold, busy, done}), 64'd0);
        tick();

        // 2: three words with gaps on rx_valid
        prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08,
                 8'h10, 8'h00, 8'hFF, 8'hFD};
        gaps = '{0, 2, 0, 1, 3, 0, 1, 0, 2, 0, 0, 4};
        expect_program();
        check("model_addr2", 64'(exp_q[2].addr), 64'h8);
        check("model_word2", 64'(exp_q[2].data), 64'h1000FFFD);
        start_session(3);
        send_program(0);
        wait_done(10);
        check("t2_all_written", 64'(exp_q.size()), 64'd0);

        // 3: zero words
        start_session(0);
        @(negedge clk);
        check("t3_done", 64'({done, busy, cpu_hold, mem_we}), 64'b1110);
        @(negedge clk);
        check("t3_after", 64'({done, busy, cpu_hold}), 64'd0);
        tick();

        // 4: too many words
        start_session(MEM_WORDS + 1);
        @(negedge clk);
        check("t4_err", 64'({err, rx_ready, busy, mem_we}), 64'b1000);
        @(negedge clk);
        check("t4_after", 64'({err, rx_ready, busy}), 64'd0);
        tick();

        // 5: reset in the middle of a word
        start_session(1);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_reset_flags", 64'({rx_ready, mem_we, cpu_hold, busy, done, err}), 64'd0);
        tick();
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        gaps = {};
        expect_program();
        start_session(1);
        send_program(0);
        wait_done(10);
        check("t5_all_written", 64'(exp_q.size()), 64'd0);

        // 6: rx_valid in IDLE, then start while busy
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_idle_ready", 64'(rx_ready), 64'd0);
            tick();
        end
        rx_valid = 1'b0;
        prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_program();
        start_session(2);
        send_byte(prog[0], 0);
        send_byte(prog[1], 1);
        start      = 1'b1;
        word_count = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t6_still_recv", 64'({busy, rx_ready, done}), 64'b110);
        tick();
        send_program(2);
        wait_done(10);
        check("t6_all_written", 64'(exp_q.size()), 64'd0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
